// File: rtl/serial_link_controller.sv
// Sequencing controller for the serial bit-count link: arms the detector, gates the
// collector and transmitter, and checks transmitter completion against the collected length.
module serial_link_controller #(
    parameter int NT_WIDTH        = 8,
    parameter int SLACK           = 4,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       detected,
    input  logic                       collect_valid,
    input  logic [NT_WIDTH-1:0]        nt,
    input  logic                       tx_done,
    input  logic                       abort,
    output logic                       det_clear,
    output logic                       collect_en,
    output logic                       tx_en,
    output logic                       busy,
    output logic                       err,
    output logic [1:0]                 state,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        HUNT     = 2'b00,
        COLLECT  = 2'b01,
        TRANSMIT = 2'b10,
        ERROR    = 2'b11
    } state_t;

    localparam logic [NT_WIDTH:0] SLACK_W = (NT_WIDTH+1)'(SLACK);

    state_t                     state_q, state_d;
    logic                       det_clear_q, det_clear_d;
    logic                       collect_en_q, collect_en_d;
    logic                       tx_en_q, tx_en_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic [NT_WIDTH-1:0]        nt_q, nt_d;
    logic [NT_WIDTH:0]          tx_cnt_q, tx_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [NT_WIDTH:0]          tx_limit;

    // Last TRANSMIT cycle index at which tx_done is still accepted.
    assign tx_limit = {1'b0, nt_q} + SLACK_W;

    always_comb begin
        state_d     = state_q;
        det_clear_d = 1'b0;
        err_d       = err_q;
        nt_d        = nt_q;
        tx_cnt_d    = tx_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if (abort) begin
            state_d     = HUNT;
            det_clear_d = 1'b1;
            err_d       = 1'b0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (detected) begin
                        state_d     = COLLECT;
                        det_clear_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (collect_valid) begin
                        nt_d     = nt;
                        tx_cnt_d = '0;
                        if (nt == '0) begin
                            state_d     = HUNT;
                            det_clear_d = 1'b1;
                        end else begin
                            state_d = TRANSMIT;
                        end
                    end
                end
                TRANSMIT: begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_done) begin
                        if (tx_cnt_q < {1'b0, nt_q}) begin
                            state_d     = ERROR;
                            err_d       = 1'b1;
                            det_clear_d = 1'b1;
                        end else begin
                            // Counter never passes tx_limit, so any later done is in-window.
                            state_d     = HUNT;
                            frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
                            det_clear_d = 1'b1;
                        end
                    end else if (tx_cnt_q == tx_limit) begin
                        state_d     = ERROR;
                        err_d       = 1'b1;
                        det_clear_d = 1'b1;
                    end
                end
                ERROR: begin
                    det_clear_d = 1'b1;
                end
                default: state_d = HUNT;
            endcase
        end

        collect_en_d = (state_d == COLLECT);
        tx_en_d      = (state_d == TRANSMIT);
        busy_d       = (state_d != HUNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HUNT;
            det_clear_q  <= 1'b0;
            collect_en_q <= 1'b0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            nt_q         <= '0;
            tx_cnt_q     <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            det_clear_q  <= det_clear_d;
            collect_en_q <= collect_en_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            nt_q         <= nt_d;
            tx_cnt_q     <= tx_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign det_clear  = det_clear_q;
    assign collect_en = collect_en_q;
    assign tx_en      = tx_en_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign state      = state_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_link_controller.sv
// Directed bench for serial_link_controller: nominal, timeout, early done, zero count,
// abort priority, frame counter wrap and asynchronous reset mid-frame.
module tb_serial_link_controller;

    logic       clk;
    logic       rst;
    logic       detected;
    logic       collect_valid;
    logic [7:0] nt;
    logic       tx_done;
    logic       abort;
    logic       det_clear;
    logic       collect_en;
    logic       tx_en;
    logic       busy;
    logic       err;
    logic [1:0] state;
    logic [7:0] frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_frame = 0;

    serial_link_controller #(.NT_WIDTH(8), .SLACK(4), .FRAME_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .detected(detected), .collect_valid(collect_valid),
        .nt(nt), .tx_done(tx_done), .abort(abort), .det_clear(det_clear),
        .collect_en(collect_en), .tx_en(tx_en), .busy(busy), .err(err),
        .state(state), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // HUNT -> COLLECT -> TRANSMIT; returns in TRANSMIT cycle with tx_cnt=0.
    task automatic start_frame(input logic [7:0] ntv);
        detected = 1'b1;
        tick();
        detected = 1'b0;
        tick();
        collect_valid = 1'b1;
        nt = ntv;
        tick();
        collect_valid = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int cnt;
        logic any_err;
        rst = 1'b0; detected = 1'b0; collect_valid = 1'b0; nt = '0;
        tx_done = 1'b0; abort = 1'b0;
        #12;
        check("rst_state", state, 0);
        check("rst_outs", {det_clear, collect_en, tx_en, busy, err}, 0);
        check("rst_frame", frame_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_state", state, 0);

        // Nominal frame, nt=5, done at tx_cnt=5
        detected = 1'b1;
        tick();
        detected = 1'b0;
        check("nom_collect", {state, collect_en, det_clear, busy}, {2'b01, 3'b111});
        tick();
        check("nom_detclr_drop", det_clear, 0);
        for (int i = 0; i < 6; i++) tick();
        check("nom_still_collect", {state, collect_en}, {2'b01, 1'b1});
        collect_valid = 1'b1; nt = 8'd5;
        tick();
        collect_valid = 1'b0;
        check("nom_transmit", {state, tx_en, collect_en, det_clear}, {2'b10, 3'b100});
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (tx_en) cnt++;
            tx_done = (i == 5);
            tick();
        end
        tx_done = 1'b0;
        exp_frame = (exp_frame + 1) % 256;
        check("nom_tx_cycles", cnt, 6);
        check("nom_done", {state, tx_en, det_clear, err}, {2'b00, 3'b010});
        check("nom_frame", frame_cnt, exp_frame);
        tick();
        check("nom_detclr_end", det_clear, 0);

        // Timeout, nt=3: tx_en high for 3+4+1 cycles
        start_frame(8'd3);
        cnt = 0;
        for (int i = 0; i < 20 && state == 2'b10; i++) begin
            if (tx_en) cnt++;
            tick();
        end
        check("to_tx_cycles", cnt, 8);
        check("to_error", {state, err, det_clear, tx_en}, {2'b11, 3'b110});
        check("to_frame", frame_cnt, exp_frame);
        tick();
        check("to_detclr_held", {state, det_clear}, {2'b11, 1'b1});
        detected = 1'b1; tx_done = 1'b1;
        tick();
        detected = 1'b0; tx_done = 1'b0;
        check("err_ignores_inputs", {state, err}, {2'b11, 1'b1});
        do_abort();
        check("to_abort", {state, err, det_clear}, {2'b00, 1'b0, 1'b1});
        tick();
        check("to_abort_pulse", det_clear, 0);

        // Early done at tx_cnt=2 with nt=6
        start_frame(8'd6);
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("early_err", {state, err}, {2'b11, 1'b1});
        check("early_frame", frame_cnt, exp_frame);
        do_abort();

        // Zero count goes straight back to HUNT
        detected = 1'b1;
        tick();
        detected = 1'b0;
        collect_valid = 1'b1; nt = 8'd0;
        tick();
        collect_valid = 1'b0;
        check("zero_hunt", {state, tx_en, det_clear}, {2'b00, 1'b0, 1'b1});
        check("zero_frame", frame_cnt, exp_frame);
        tick();
        check("zero_no_tx", tx_en, 0);

        // detected and collect_valid together in HUNT only reach COLLECT
        detected = 1'b1; collect_valid = 1'b1; nt = 8'd4;
        tick();
        detected = 1'b0; collect_valid = 1'b0;
        check("one_step", state, 2'b01);
        // abort together with collect_valid wins
        collect_valid = 1'b1; abort = 1'b1;
        tick();
        collect_valid = 1'b0; abort = 1'b0;
        check("abort_vs_cv", {state, tx_en}, {2'b00, 1'b0});

        // abort together with an in-window done
        start_frame(8'd2);
        tick(); tick();
        tx_done = 1'b1; abort = 1'b1;
        tick();
        tx_done = 1'b0; abort = 1'b0;
        check("abort_vs_done", {state, err, det_clear}, {2'b00, 1'b0, 1'b1});
        check("abort_vs_done_frame", frame_cnt, exp_frame);

        // 256 frames, nt=1, done at the last legal cycle (tx_cnt=5)
        any_err = 1'b0;
        for (int f = 0; f < 256; f++) begin
            start_frame(8'd1);
            for (int i = 0; i < 5; i++) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (err || state != 2'b00) any_err = 1'b1;
            exp_frame = (exp_frame + 1) % 256;
            if (f == 254) check("wrap_zero", frame_cnt, 0);
        end
        check("wrap_no_err", any_err, 0);
        check("wrap_frame", frame_cnt, exp_frame);

        // Asynchronous reset between edges during TRANSMIT
        start_frame(8'd4);
        tick();
        check("pre_rst_tx", tx_en, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_outs", {state, det_clear, collect_en, tx_en, busy, err}, 0);
        check("mid_rst_frame", frame_cnt, 0);
        #3 rst = 1'b1;
        tick();
        check("post_rst", {state, det_clear}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
